prog_loader: RTL and testbench

//  Boot-time program loader upstream of the single-cycle CPU's instruction memory.

---
 rtl/prog_loader_pkg.sv | 18 +
 rtl/prog_loader.sv | 117 +++++++++++
 tb/tb_prog_loader.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared FSM encoding and frame constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    localparam logic [7:0] MAGIC_DEFAULT   = 8'hA5;
    localparam int         ADDR_W_DEFAULT  = 6;
    localparam int         MAX_FRAME_WORDS = 64;

endpackage

// File: rtl/prog_loader.sv
// Purpose: unpack a MAGIC/N/payload/CSUM byte frame into 32-bit imem writes; hold the CPU until a good frame lands.
// Latency: 4th byte of a word accepted on edge k -> imem_we high for the following cycle.
// Backpressure: rx_ready drops only during the single write cycle; rx_valid low stalls indefinitely.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         ADDR_W = ADDR_W_DEFAULT,
    parameter int         DEPTH  = MAX_FRAME_WORDS,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        csum;
    logic [23:0]       word_sr;     // first three bytes of the word being assembled
    logic              rx_acc;
    logic              is_magic;
    logic              bad_count;
    logic              last_word;

    assign rx_acc    = rx_valid & rx_ready;
    assign is_magic  = (rx_data == MAGIC);
    assign bad_count = (rx_data == 8'd0) || ({24'd0, rx_data} > DEPTH_U);
    assign last_word = ((word_idx + IDX_ONE) == n_words);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = (state != ST_WRITE);
        imem_we   = (state == ST_WRITE);
        cpu_hold  = (state != ST_DONE);
        done      = (state == ST_DONE);
        error     = (state == ST_ERR);
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_acc && is_magic) state_nxt = ST_COUNT;
            end
            ST_COUNT: begin
                if (rx_acc) state_nxt = bad_count ? ST_ERR : ST_DATA;
            end
            ST_DATA: begin
                if (rx_acc && byte_idx == 2'd3) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                state_nxt = last_word ? ST_CHECK : ST_DATA;
            end
            ST_CHECK: begin
                if (rx_acc) state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // imem_addr/imem_wd are loaded on the 4th-byte edge so they are valid during WRITE and hold afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_words   <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            word_sr   <= '0;
            imem_addr <= '0;
            imem_wd   <= '0;
        end else begin
            case (state)
                ST_COUNT: begin
                    if (rx_acc && !bad_count) begin
                        n_words  <= (ADDR_W+1)'(rx_data);
                        word_idx <= '0;
                        byte_idx <= '0;
                        csum     <= '0;
                    end
                end
                ST_DATA: begin
                    if (rx_acc) begin
                        word_sr  <= {word_sr[15:0], rx_data};
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            imem_addr <= word_idx[ADDR_W-1:0];
                            imem_wd   <= {word_sr, rx_data};
                        end
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_idx + IDX_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader against a frame-level model of expected writes and status.
module tb_prog_loader;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int n_vec = 0;
    int n_err = 0;
    int gap_max = 0;
    int cyc = 0;

    logic [31:0]  words[$];
    int unsigned  wr_a[$];
    logic [31:0]  wr_d[$];

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAGIC(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Instruction-memory write log, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_a.push_back(int'(imem_addr));
            wr_d.push_back(imem_wd);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Checksum model: XOR of every payload byte equals the byte-fold of the XOR of all words.
    function automatic logic [7:0] model_csum();
        logic [31:0] x;
        x = '0;
        foreach (words[i]) x ^= words[i];
        return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int  w;
        bit  ok;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        w  = 0;
        ok = 0;
        while (!ok && w < 8) begin
            @(negedge clk);
            if (rx_ready === 1'b1) ok = 1;
            else w++;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_ready_timeout: byte %h not accepted within 8 cycles", b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] n, input logic [7:0] csum_xor);
        wr_a.delete();
        wr_d.delete();
        send_byte(8'hA5);
        send_byte(n);
        foreach (words[i])
            for (int j = 0; j < 4; j++) send_byte(words[i][31-8*j -: 8]);
        send_byte(model_csum() ^ csum_xor);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (2) @(negedge clk);
        n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b want 1", rx_ready); end
        n_vec++; if (imem_we !== 1'b0) begin n_err++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
        n_vec++; if (imem_addr !== '0) begin n_err++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
        n_vec++; if (imem_wd !== 32'h0) begin n_err++; $display("FAIL reset_imem_wd: got %h want 0", imem_wd); end
        n_vec++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_vec++; if (error !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", error); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        gap_max = 0;
        words = '{32'h20080005, 32'h01095020};
        send_frame(8'd2, 8'h00);
        n_vec++; if (cpu_hold !== 1'b0) begin n_err++; $display("FAIL normal_cpu_hold: got %b want 0", cpu_hold); end
        n_vec++; if (done !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL normal_status: got done=%b error=%b want 1/0", done, error); end
        n_vec++; if (wr_a.size() != 2) begin n_err++; $display("FAIL normal_wr_count: got %0d want 2", wr_a.size()); end
        foreach (words[i]) if (i < wr_a.size()) begin
            n_vec++;
            if (wr_a[i] != i || wr_d[i] !== words[i]) begin
                n_err++; $display("FAIL normal_write%0d: got [%0d]=%h want [%0d]=%h", i, wr_a[i], wr_d[i], i, words[i]);
            end
        end
    endtask

    task automatic test_bad_csum();
        words = '{32'h20080005, 32'h01095020};
        send_frame(8'd2, model_csum());   // checksum byte of 0x00
        n_vec++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_err++; $display("FAIL badcsum_status: got err=%b done=%b hold=%b want 1/0/1", error, done, cpu_hold);
        end
        n_vec++; if (wr_a.size() != 2) begin n_err++; $display("FAIL badcsum_wr_count: got %0d want 2", wr_a.size()); end
    endtask

    task automatic test_bad_count();
        logic [7:0] bad_n[2];
        bad_n[0] = 8'h00;
        bad_n[1] = 8'h41;
        for (int k = 0; k < 2; k++) begin
            wr_a.delete();
            wr_d.delete();
            send_byte(8'hA5);
            send_byte(bad_n[k]);
            repeat (3) @(negedge clk);
            n_vec++; if (error !== 1'b1 || cpu_hold !== 1'b1) begin
                n_err++; $display("FAIL badcount_%h_status: got err=%b hold=%b want 1/1", bad_n[k], error, cpu_hold);
            end
            n_vec++; if (wr_a.size() != 0) begin n_err++; $display("FAIL badcount_%h_writes: got %0d want 0", bad_n[k], wr_a.size()); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_noise_reload();
        send_byte(8'h11);
        send_byte(8'h22);
        n_vec++; if (error !== 1'b1) begin n_err++; $display("FAIL noise_err_kept: got %b want 1", error); end
        words = '{$urandom};
        send_frame(8'd1, 8'h00);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL noise_load_done: got %b want 1", done); end
        send_byte(8'h11);
        n_vec++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_err++; $display("FAIL done_noise: got done=%b hold=%b want 1/0", done, cpu_hold); end
        send_byte(8'hA5);
        n_vec++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL reload_magic: got hold=%b done=%b want 1/0", cpu_hold, done); end
        words = '{32'hA5A5_0A5A};
        wr_a.delete();
        wr_d.delete();
        send_byte(8'd1);
        for (int j = 0; j < 4; j++) send_byte(words[0][31-8*j -: 8]);
        send_byte(model_csum());
        n_vec++; if (wr_a.size() != 1 || wr_a[0] != 0 || wr_d[0] !== words[0] || done !== 1'b1) begin
            n_err++; $display("FAIL reload_word0: got n=%0d done=%b want [0]=%h done=1", wr_a.size(), done, words[0]);
        end
    endtask

    task automatic test_backpressure();
        int c0;
        gap_max = 0;
        words = '{$urandom, $urandom};
        wr_a.delete();
        wr_d.delete();
        c0 = cyc;
        send_byte(8'hA5);
        send_byte(8'd2);
        foreach (words[i]) begin
            for (int j = 0; j < 4; j++) send_byte(words[i][31-8*j -: 8]);
            n_vec++; if (imem_we !== 1'b1 || rx_ready !== 1'b0 || imem_addr !== ADDR_W'(i) || imem_wd !== words[i]) begin
                n_err++; $display("FAIL bp_write%0d: got we=%b rdy=%b [%0d]=%h want 1/0 [%0d]=%h",
                                  i, imem_we, rx_ready, imem_addr, imem_wd, i, words[i]);
            end
        end
        send_byte(model_csum());
        // 3 header/trailer bytes + 4 bytes and one write cycle per word, with no idle cycles
        n_vec++; if (cyc - c0 != 13) begin n_err++; $display("FAIL bp_cycles: got %0d want 13", cyc - c0); end
        n_vec++; if (done !== 1'b1 || wr_a.size() != 2) begin n_err++; $display("FAIL bp_done: got done=%b n=%0d want 1/2", done, wr_a.size()); end
        gap_max = 3;
        send_frame(8'd2, 8'h00);
        n_vec++; if (done !== 1'b1 || wr_a.size() != 2 || wr_d[0] !== words[0] || wr_d[1] !== words[1]) begin
            n_err++; $display("FAIL stall_writes: got done=%b n=%0d want identical writes", done, wr_a.size());
        end
        gap_max = 0;
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5);
        send_byte(8'd1);
        send_byte(8'h12);
        send_byte(8'h34);
        reset = 1'b0;
        #1;
        n_vec++; if (rx_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wd !== 32'h0 ||
                     cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b want 1/0/0/0/1/0/0",
                              rx_ready, imem_we, imem_addr, imem_wd, cpu_hold, done, error);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h11);
        send_byte(8'h22);
        words = '{$urandom};
        send_frame(8'd1, 8'h00);
        n_vec++; if (done !== 1'b1 || wr_a.size() != 1 || wr_a[0] != 0 || wr_d[0] !== words[0]) begin
            n_err++; $display("FAIL midreset_reload: got done=%b n=%0d want done=1 [0]=%h", done, wr_a.size(), words[0]);
        end
    endtask

    task automatic test_max_frame();
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        send_frame(8'(DEPTH), 8'h00);
        n_vec++; if (done !== 1'b1 || wr_a.size() != DEPTH) begin n_err++; $display("FAIL max_frame: got done=%b n=%0d want 1/%0d", done, wr_a.size(), DEPTH); end
        n_vec++; if (wr_a.size() == DEPTH && (wr_a[DEPTH-1] != DEPTH-1 || wr_d[DEPTH-1] !== words[DEPTH-1])) begin
            n_err++; $display("FAIL max_frame_last: got [%0d]=%h want [%0d]=%h", wr_a[DEPTH-1], wr_d[DEPTH-1], DEPTH-1, words[DEPTH-1]);
        end
    endtask

    task automatic test_random();
        int          n;
        bit          bad_n;
        logic [7:0]  cx;
        logic [7:0]  noise;
        for (int f = 0; f < 20; f++) begin
            gap_max = $urandom_range(0, 2);
            repeat ($urandom_range(0, 2)) begin
                noise = 8'($urandom_range(0, 255));
                if (noise == 8'hA5) noise = 8'h5A;
                send_byte(noise);
            end
            bad_n = ($urandom_range(0, 5) == 0);
            n = bad_n ? (($urandom_range(0, 1) == 1) ? 0 : $urandom_range(DEPTH + 1, 255)) : $urandom_range(1, 6);
            cx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            words.delete();
            if (bad_n) begin
                wr_a.delete();
                wr_d.delete();
                send_byte(8'hA5);
                send_byte(8'(n));
                repeat (2) @(negedge clk);
                n_vec++; if (error !== 1'b1 || wr_a.size() != 0) begin
                    n_err++; $display("FAIL rand%0d_badn: got err=%b n=%0d want 1/0 (N=%0d)", f, error, wr_a.size(), n);
                end
                @(posedge clk);
                #1;
            end else begin
                for (int i = 0; i < n; i++) words.push_back(($urandom_range(0, 3) == 0) ? 32'hA5A5A5A5 : $urandom);
                send_frame(8'(n), cx);
                n_vec++; if (done !== (cx == 8'h00) || error !== (cx != 8'h00) || cpu_hold !== (cx != 8'h00)) begin
                    n_err++; $display("FAIL rand%0d_status: got done=%b err=%b hold=%b csum_ok=%b", f, done, error, cpu_hold, cx == 8'h00);
                end
                n_vec++; if (wr_a.size() != n) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", f, wr_a.size(), n); end
                foreach (words[i]) if (i < wr_a.size()) begin
                    n_vec++;
                    if (wr_a[i] != i || wr_d[i] !== words[i]) begin
                        n_err++; $display("FAIL rand%0d_write%0d: got [%0d]=%h want [%0d]=%h", f, i, wr_a[i], wr_d[i], i, words[i]);
                    end
                end
            end
        end
        gap_max = 0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_bad_csum();
        test_bad_count();
        test_noise_reload();
        test_backpressure();
        test_reset_midframe();
        test_max_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
